// File: rtl/id_link_pkg.sv
// Shared types and constants for the multi-board ID negotiation link.
package id_link_pkg;

    localparam logic [3:0] FRAME_TAG = 4'hA;

    localparam logic [1:0] ID_1    = 2'b01;
    localparam logic [1:0] ID_2    = 2'b10;
    localparam logic [1:0] ID_NONE = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LISTEN,
        ST_LOCK,
        ST_SETTLE,
        ST_ANNOUNCE
    } ctrl_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    function automatic logic [7:0] id_frame(input logic [1:0] id);
        return {FRAME_TAG, 2'b00, id};
    endfunction

endpackage

// File: rtl/id_frame_rx.sv
// 8N1 serial receiver for ID announcements: synchronizer, bit timing and byte assembly.
module id_frame_rx
    import id_link_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 564
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       frame_valid,
    output logic [7:0] frame_byte
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    rx_state_t        state;
    logic             rx_meta;
    logic             rx_sync;
    logic             rx_prev;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta     <= 1'b1;
            rx_sync     <= 1'b1;
            rx_prev     <= 1'b1;
            state       <= RX_IDLE;
            cnt         <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            frame_valid <= 1'b0;
            frame_byte  <= '0;
        end else begin
            rx_meta     <= rx;
            rx_sync     <= rx_meta;
            rx_prev     <= rx_sync;
            frame_valid <= 1'b0;
            case (state)
                RX_IDLE: begin
                    // Edge is seen one cycle after rx_sync falls, so the count starts at 1
                    if (rx_prev && !rx_sync) begin
                        state <= RX_START;
                        cnt   <= CNT_W'(1);
                    end
                end
                RX_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_cnt <= '0;
                        state   <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        shift <= {rx_sync, shift[7:1]};
                        if (bit_cnt == 3'd7) begin
                            state <= RX_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        state <= RX_IDLE;
                        if (rx_sync) begin
                            frame_valid <= 1'b1;
                            frame_byte  <= shift;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/id_link.sv
// ID negotiation link: listens for peer announcements, locks after a listen
// window, then periodically broadcasts this board's own ID.
module id_link
    import id_link_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT  = 564,
    parameter int unsigned LISTEN_CYCLES = 65_000_000,
    parameter int unsigned BEACON_CYCLES = 6_500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       rx,
    input  logic [1:0] board_ID,
    output logic       lock_ID_en,
    output logic       external_ID_1,
    output logic       external_ID_2,
    output logic       tx,
    output logic       tx_busy
);

    localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);
    localparam int unsigned LISTEN_W = $clog2(LISTEN_CYCLES);
    localparam int unsigned BEACON_W = $clog2(BEACON_CYCLES);
    localparam logic [CNT_W-1:0]    BIT_LAST    = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [LISTEN_W-1:0] LISTEN_LAST = LISTEN_W'(LISTEN_CYCLES - 1);
    localparam logic [BEACON_W-1:0] BEACON_LAST = BEACON_W'(BEACON_CYCLES - 1);

    ctrl_state_t       state;
    logic [LISTEN_W-1:0] listen_cnt;
    logic [BEACON_W-1:0] beacon_cnt;
    logic              settle_cnt;
    logic              frame_valid;
    logic [7:0]        frame_byte;
    logic              frame_start;
    logic [8:0]        tx_shift;
    logic [3:0]        tx_bit;
    logic [CNT_W-1:0]  tx_cnt;

    id_frame_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx          (rx),
        .frame_valid (frame_valid),
        .frame_byte  (frame_byte)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            external_ID_1 <= 1'b0;
            external_ID_2 <= 1'b0;
        end else if (frame_valid) begin
            if (frame_byte == id_frame(ID_1)) external_ID_1 <= 1'b1;
            if (frame_byte == id_frame(ID_2)) external_ID_2 <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            listen_cnt <= '0;
            beacon_cnt <= '0;
            settle_cnt <= 1'b0;
            lock_ID_en <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_LISTEN;
                        listen_cnt <= '0;
                    end
                end
                ST_LISTEN: begin
                    if (listen_cnt == LISTEN_LAST) begin
                        state <= ST_LOCK;
                    end else begin
                        listen_cnt <= listen_cnt + LISTEN_W'(1);
                    end
                end
                ST_LOCK: begin
                    lock_ID_en <= 1'b1;
                    settle_cnt <= 1'b0;
                    state      <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_cnt) begin
                        state      <= ST_ANNOUNCE;
                        beacon_cnt <= '0;
                    end else begin
                        settle_cnt <= 1'b1;
                    end
                end
                ST_ANNOUNCE: begin
                    // Timer free-runs even when no frame is sent for this ID
                    beacon_cnt <= (beacon_cnt == BEACON_LAST) ? '0 : beacon_cnt + BEACON_W'(1);
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        frame_start = 1'b0;
        if (state == ST_ANNOUNCE && beacon_cnt == '0 &&
            board_ID != ID_NONE && board_ID != 2'b00) begin
            frame_start = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
            tx_shift <= '0;
            tx_bit   <= '0;
            tx_cnt   <= '0;
        end else if (frame_start) begin
            tx       <= 1'b0;
            tx_busy  <= 1'b1;
            tx_shift <= {1'b1, id_frame(board_ID)};
            tx_bit   <= '0;
            tx_cnt   <= '0;
        end else if (tx_busy) begin
            if (tx_cnt == BIT_LAST) begin
                tx_cnt <= '0;
                if (tx_bit == 4'd9) begin
                    tx_busy <= 1'b0;
                end else begin
                    tx       <= tx_shift[0];
                    tx_shift <= {1'b1, tx_shift[8:1]};
                    tx_bit   <= tx_bit + 4'd1;
                end
            end else begin
                tx_cnt <= tx_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_id_link.sv
// Self-checking bench for id_link with short bit, listen and beacon periods.
module tb_id_link;

    localparam int C  = 8;
    localparam int LC = 200;
    localparam int BC = 300;
    localparam int STOP_SAMPLE = 2 + 9 * C + C / 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       rx;
    logic [1:0] board_ID;
    logic       lock_ID_en;
    logic       external_ID_1;
    logic       external_ID_2;
    logic       tx;
    logic       tx_busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] tx_exp_q[$];
    logic [1:0] flag_exp_q[$];
    logic [1:0] model_flags;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    id_link #(
        .CLKS_PER_BIT  (C),
        .LISTEN_CYCLES (LC),
        .BEACON_CYCLES (BC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .rx            (rx),
        .board_ID      (board_ID),
        .lock_ID_en    (lock_ID_en),
        .external_ID_1 (external_ID_1),
        .external_ID_2 (external_ID_2),
        .tx            (tx),
        .tx_busy       (tx_busy)
    );

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        rx    = 1'b1;
        model_flags = 2'b00;
        flag_exp_q.delete();
        tx_exp_q.delete();
        wait_edges(3);
        rst_n = 1'b1;
        wait_edges(2);
    endtask

    task automatic pulse_start(output int n);
        start = 1'b1;
        wait_edges(1);
        start = 1'b0;
        n = cyc;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            wait_edges(C);
        end
        rx = 1'b1;
    endtask

    task automatic expect_frame(input logic [7:0] b, input logic stop_bit);
        if (stop_bit && b == 8'hA1) model_flags[0] = 1'b1;
        if (stop_bit && b == 8'hA2) model_flags[1] = 1'b1;
        flag_exp_q.push_back(model_flags);
    endtask

    task automatic wait_lock(input int bound, output int l);
        l = -1;
        for (int i = 0; i < bound; i++) begin
            wait_edges(1);
            if (lock_ID_en === 1'b1) begin
                l = cyc;
                break;
            end
        end
    endtask

    task automatic capture_tx(input int bound, output logic [7:0] b, output logic stop,
                              output int f, output logic busy0);
        f = -1;
        b = 8'hxx;
        stop = 1'bx;
        busy0 = 1'bx;
        for (int i = 0; i < bound; i++) begin
            wait_edges(1);
            if (tx === 1'b0) begin
                f = cyc;
                break;
            end
        end
        if (f >= 0) begin
            busy0 = tx_busy;
            wait_edges(C / 2);
            for (int i = 0; i < 8; i++) begin
                wait_edges(C);
                b[i] = tx;
            end
            wait_edges(C);
            stop = tx;
        end
    endtask

    task automatic run_beacon_scenario(input string tag);
        int n, l, f, f2;
        logic [7:0] b, exp;
        logic stop, busy0;
        board_ID = 2'b01;
        tx_exp_q.push_back(8'hA1);
        tx_exp_q.push_back(8'hA1);
        pulse_start(n);
        wait_lock(LC + 20, l);
        checks++;
        if (l != n + LC + 1) begin
            errors++;
            $display("FAIL %s lock_edge: got start+%0d required start+%0d", tag, l - n, LC + 1);
        end
        checks++;
        if ({external_ID_2, external_ID_1} !== 2'b00) begin
            errors++;
            $display("FAIL %s flags_at_lock: got %b required 00", tag, {external_ID_2, external_ID_1});
        end
        capture_tx(20, b, stop, f, busy0);
        exp = (tx_exp_q.size() > 0) ? tx_exp_q.pop_front() : 8'hxx;
        checks++;
        if (f != l + 3) begin
            errors++;
            $display("FAIL %s first_frame_edge: got lock+%0d required lock+3", tag, f - l);
        end
        checks++;
        if (busy0 !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_at_start: got %b required 1", tag, busy0);
        end
        checks++;
        if (b !== exp || stop !== 1'b1) begin
            errors++;
            $display("FAIL %s frame1: got %h stop %b required %h stop 1", tag, b, stop, exp);
        end
        capture_tx(BC + 20, b, stop, f2, busy0);
        exp = (tx_exp_q.size() > 0) ? tx_exp_q.pop_front() : 8'hxx;
        checks++;
        if (f2 - f != BC) begin
            errors++;
            $display("FAIL %s beacon_period: got %0d required %0d", tag, f2 - f, BC);
        end
        checks++;
        if (b !== exp || stop !== 1'b1) begin
            errors++;
            $display("FAIL %s frame2: got %h stop %b required %h stop 1", tag, b, stop, exp);
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        start    = 1'b0;
        rx       = 1'b1;
        board_ID = 2'b01;
        wait_edges(3);
        checks++;
        if ({lock_ID_en, external_ID_2, external_ID_1, tx, tx_busy} !== 5'b00010) begin
            errors++;
            $display("FAIL reset_values: got %b required 00010",
                     {lock_ID_en, external_ID_2, external_ID_1, tx, tx_busy});
        end
        rst_n = 1'b1;
        wait_edges(LC + 20);
        checks++;
        if ({lock_ID_en, tx, tx_busy} !== 3'b010) begin
            errors++;
            $display("FAIL idle_without_start: got %b required 010", {lock_ID_en, tx, tx_busy});
        end
    endtask

    task automatic test_beacon();
        do_reset();
        run_beacon_scenario("beacon");
    endtask

    task automatic test_rx_flags();
        int n, l;
        logic [1:0] exp;
        do_reset();
        board_ID = 2'b01;
        expect_frame(8'hA1, 1'b1);
        fork
            send_rx(8'hA1, 1'b1);
            begin
                wait_edges(STOP_SAMPLE);
                checks++;
                if ({external_ID_2, external_ID_1} !== 2'b00) begin
                    errors++;
                    $display("FAIL ext1_early: got %b required 00", {external_ID_2, external_ID_1});
                end
                wait_edges(1);
                exp = flag_exp_q.pop_front();
                checks++;
                if ({external_ID_2, external_ID_1} !== exp) begin
                    errors++;
                    $display("FAIL ext1_latency: got %b required %b", {external_ID_2, external_ID_1}, exp);
                end
            end
        join
        pulse_start(n);
        expect_frame(8'hA2, 1'b1);
        fork
            send_rx(8'hA2, 1'b1);
            begin
                wait_edges(STOP_SAMPLE + 1);
                exp = flag_exp_q.pop_front();
                checks++;
                if ({external_ID_2, external_ID_1} !== exp) begin
                    errors++;
                    $display("FAIL ext2_in_listen: got %b required %b", {external_ID_2, external_ID_1}, exp);
                end
            end
        join
        wait_lock(LC + 20, l);
        checks++;
        if (l != n + LC + 1 || {external_ID_2, external_ID_1} !== 2'b11) begin
            errors++;
            $display("FAIL flags_through_lock: got edge start+%0d flags %b required start+%0d flags 11",
                     l - n, {external_ID_2, external_ID_1}, LC + 1);
        end
        expect_frame(8'hA1, 1'b1);
        send_rx(8'hA1, 1'b1);
        exp = flag_exp_q.pop_front();
        checks++;
        if ({external_ID_2, external_ID_1} !== exp || lock_ID_en !== 1'b1) begin
            errors++;
            $display("FAIL duplicate_frame: got flags %b lock %b required %b lock 1",
                     {external_ID_2, external_ID_1}, lock_ID_en, exp);
        end
    endtask

    task automatic test_rx_reject();
        logic [7:0] bytes [3];
        logic       stops [3];
        logic [1:0] exp;
        bytes = '{8'hB1, 8'hA3, 8'hA1};
        stops = '{1'b1, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            expect_frame(bytes[i], stops[i]);
            send_rx(bytes[i], stops[i]);
            wait_edges(2 * C);
            exp = flag_exp_q.pop_front();
            checks++;
            if ({external_ID_2, external_ID_1} !== exp) begin
                errors++;
                $display("FAIL reject_%h_stop%b: got %b required %b",
                         bytes[i], stops[i], {external_ID_2, external_ID_1}, exp);
            end
        end
        flag_exp_q.push_back(model_flags);
        rx = 1'b0;
        wait_edges(2);
        rx = 1'b1;
        wait_edges(12 * C);
        exp = flag_exp_q.pop_front();
        checks++;
        if ({external_ID_2, external_ID_1} !== exp) begin
            errors++;
            $display("FAIL glitch: got %b required %b", {external_ID_2, external_ID_1}, exp);
        end
        expect_frame(8'hA2, 1'b1);
        send_rx(8'hA2, 1'b1);
        exp = flag_exp_q.pop_front();
        checks++;
        if ({external_ID_2, external_ID_1} !== exp) begin
            errors++;
            $display("FAIL valid_after_rejects: got %b required %b", {external_ID_2, external_ID_1}, exp);
        end
    endtask

    task automatic test_id_none();
        int n, l, f, bad;
        logic [7:0] b, exp;
        logic stop, busy0;
        do_reset();
        board_ID = 2'b11;
        pulse_start(n);
        wait_lock(LC + 20, l);
        checks++;
        if (l != n + LC + 1) begin
            errors++;
            $display("FAIL none_lock_edge: got start+%0d required start+%0d", l - n, LC + 1);
        end
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            wait_edges(1);
            if (tx !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL none_silent: got %0d active cycles required 0", bad);
        end
        board_ID = 2'b10;
        tx_exp_q.push_back(8'hA2);
        capture_tx(BC + 20, b, stop, f, busy0);
        exp = (tx_exp_q.size() > 0) ? tx_exp_q.pop_front() : 8'hxx;
        checks++;
        if (f != l + 3 + 4 * BC || b !== exp) begin
            errors++;
            $display("FAIL none_then_id2: got lock+%0d byte %h required lock+%0d byte %h",
                     f - l, b, 3 + 4 * BC, exp);
        end
    endtask

    task automatic test_reset_mid_frame();
        int n, l, f;
        do_reset();
        board_ID = 2'b01;
        pulse_start(n);
        wait_lock(LC + 20, l);
        f = -1;
        for (int i = 0; i < 20; i++) begin
            wait_edges(1);
            if (tx === 1'b0) begin
                f = cyc;
                break;
            end
        end
        checks++;
        if (f != l + 3) begin
            errors++;
            $display("FAIL midreset_frame_start: got lock+%0d required lock+3", f - l);
        end
        wait_edges(4 * C + 2);
        checks++;
        if (tx !== 1'b0 || tx_busy !== 1'b1) begin
            errors++;
            $display("FAIL midreset_data_bit3: got tx %b busy %b required tx 0 busy 1", tx, tx_busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({lock_ID_en, external_ID_2, external_ID_1, tx, tx_busy} !== 5'b00010) begin
            errors++;
            $display("FAIL midreset_async: got %b required 00010",
                     {lock_ID_en, external_ID_2, external_ID_1, tx, tx_busy});
        end
        wait_edges(3);
        rst_n = 1'b1;
        wait_edges(2);
        run_beacon_scenario("after_reset");
    endtask

    task automatic test_coincident();
        int n;
        logic [1:0] exp;
        do_reset();
        board_ID = 2'b01;
        pulse_start(n);
        wait_edges(LC + 1 - (STOP_SAMPLE + 1));
        expect_frame(8'hA2, 1'b1);
        fork
            send_rx(8'hA2, 1'b1);
            begin
                wait_edges(STOP_SAMPLE);
                checks++;
                if (external_ID_2 !== 1'b0 || lock_ID_en !== 1'b0) begin
                    errors++;
                    $display("FAIL coincide_before: got ext2 %b lock %b required 0 0", external_ID_2, lock_ID_en);
                end
                wait_edges(1);
                exp = flag_exp_q.pop_front();
                checks++;
                if ({external_ID_2, external_ID_1} !== exp || lock_ID_en !== 1'b1) begin
                    errors++;
                    $display("FAIL coincide_edge: got flags %b lock %b at start+%0d required %b lock 1",
                             {external_ID_2, external_ID_1}, lock_ID_en, cyc - n, exp);
                end
            end
        join
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
        $fatal(1);
    end

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        rx       = 1'b1;
        board_ID = 2'b00;
        model_flags = 2'b00;
        test_reset();
        test_beacon();
        test_rx_flags();
        test_rx_reject();
        test_id_none();
        test_reset_mid_frame();
        test_coincident();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_link.md
# id_link

Upstream stage of `board_ID`: a multi-board ID negotiation link.
- Listens on a serial line for ID announcements from other boards and produces the sticky `external_ID_1` / `external_ID_2` flags.
- After a listen window following `start`, raises `lock_ID_en`.
- Once `board_ID` comes back from the downstream stage, periodically broadcasts this board's own ID on `tx`.

## Interface
Parameters:
- `CLKS_PER_BIT`, 564: clock cycles per serial bit (65 MHz / 115200).
- `LISTEN_CYCLES`, 65_000_000: listen window length after `start`.
- `BEACON_CYCLES`, 6_500_000: period between announcement frame starts. Must be greater than 10*`CLKS_PER_BIT`.

Ports:
- `clk` in 1: system clock; single clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle request to begin negotiation. Honoured only in IDLE.
- `rx` in 1: serial input from other boards; asynchronous; idles high.
- `board_ID` in 2: ID assigned by the downstream stage.
- `lock_ID_en` out 1: level; high from LOCK onward until reset.
- `external_ID_1` out 1: sticky; a valid announcement for ID 1 has been received.
- `external_ID_2` out 1: sticky; a valid announcement for ID 2 has been received.
- `tx` out 1: serial announcement output; idles high.
- `tx_busy` out 1: high while a frame is being shifted out.

## Operation
- Frame format: 8N1, LSB first.
  - Byte = {`FRAME_TAG`=4'hA, 2'b00, id[1:0]}.
  - Valid bytes: 8'hA1 (ID 1) and 8'hA2 (ID 2). All other bytes are ignored, including 8'hA3 and 8'hA0.
- Receiver:
  - `rx` passes through a 2-flop synchronizer.
  - A falling edge in idle starts reception; the start bit is re-sampled at `CLKS_PER_BIT`/2. If it reads 1, reception aborts (glitch).
  - Data bits are sampled every `CLKS_PER_BIT` cycles after that point.
  - A stop bit sampled as 0 discards the frame.
  - The receiver is active from reset in all states, so announcements from boards negotiated earlier are captured before `start`.
- Control FSM states:
  - IDLE: on `start`, go to LISTEN and clear the listen counter.
  - LISTEN: count to `LISTEN_CYCLES`-1, then go to LOCK.
  - LOCK: set `lock_ID_en`=1; next cycle go to SETTLE.
  - SETTLE: wait 2 cycles for `board_ID` to resolve, then go to ANNOUNCE.
  - ANNOUNCE:
    - Sample `board_ID` at each frame start.
    - 2'b01 or 2'b10: send {4'hA, 2'b00, board_ID}.
    - 2'b00 or 2'b11: send nothing; `tx` stays high and the beacon timer still runs.
    - Repeat every `BEACON_CYCLES` until reset.
- External flags: set on a valid frame in any state; cleared only by reset.
- Transmitter: start bit 0, 8 data bits, stop bit 1, each held `CLKS_PER_BIT` cycles; 10*`CLKS_PER_BIT` cycles in total.

## Timing
- Reset values: `lock_ID_en`=0, `external_ID_1`=0, `external_ID_2`=0, `tx`=1, `tx_busy`=0, FSM=IDLE. All counters are 0.
- Reset mid-frame (rx or tx): outputs return to reset values immediately (asynchronous); no partial frame survives.
- `start` accepted at edge N: `lock_ID_en` rises at edge N+`LISTEN_CYCLES`+1.
- First announcement start bit drives `tx` at edge L+3, where L is the edge at which `lock_ID_en` rises. `tx_busy` rises on the same edge.
- Subsequent frames start exactly `BEACON_CYCLES` after the previous frame start.
- Flag latency: the external flag rises 1 cycle after the stop-bit sample edge. The stop-bit sample occurs 2 synchronizer cycles + 9.5*`CLKS_PER_BIT` after the start-bit falling edge on `rx`.
- Frame completion on the same edge as listen expiry: the flag is set no later than `lock_ID_en`, so downstream sees both together.
- `start` pulses outside IDLE are ignored. A second valid frame for an already-set flag causes no change.

## Structure
- Package `id_link_pkg`:
  - `FRAME_TAG` (4'hA)
  - ID codes `ID_1`=2'b01, `ID_2`=2'b10, `ID_NONE`=2'b11
  - control FSM state enum
  - receiver state enum
- One sub-module, `id_frame_rx`: synchronizer, receive FSM and bit counter. Outputs a 1-cycle `frame_valid` plus `frame_byte[7:0]`.
- Transmitter, beacon timer, listen timer and control FSM live in `id_link`.

## Test plan
Benches use `CLKS_PER_BIT`=8, `LISTEN_CYCLES`=200, `BEACON_CYCLES`=300.
- No rx traffic; `start` at edge N; `board_ID`=01.
  - `lock_ID_en` rises at edge N+201 and both flags stay 0.
  - `tx` carries 8'hA1 starting 3 edges later.
  - The next frame starts 300 cycles after the first.
- rx 8'hA1 before `start`, then 8'hA2 during LISTEN: `external_ID_1`=1 then `external_ID_2`=1, each 1 cycle after its stop-bit sample; both held through LOCK.
- rx 8'hB1; rx 8'hA3; rx 8'hA1 with stop bit 0; 2-cycle low glitch on `rx`: no flag changes.
- `board_ID`=11 after lock: `tx` stays 1 and `tx_busy` stays 0 for 1000 cycles.
- `rst_n` low during the 4th data bit of an outgoing frame: `tx`=1 and all outputs reset immediately. A new `start` after release reproduces the first scenario.
- rx 8'hA2 stop-bit sample aligned so its flag edge coincides with listen expiry: `external_ID_2` is high no later than `lock_ID_en`.
